// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample path.
//   clog2     : ceiling log2 helper
//   work_w    : internal working width for a width converter
//   SAT_CNT_W : width of saturation event counters
package audio_pkg;

  localparam int unsigned SAT_CNT_W = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res++;
    end
    return res;
  endfunction

  // Wide enough that any extended sample shifted left by the maximum distance
  // still fits with a spare sign bit, so saturation sees the true value.
  function automatic int unsigned work_w(input int unsigned in_width,
                                         input int unsigned out_width,
                                         input int unsigned shift_w);
    int unsigned widest;
    widest = (in_width > out_width) ? in_width : out_width;
    return widest + (32'd1 << shift_w) + 1;
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational clamp of a WORK_W-bit value to OUT_WIDTH bits.
//   value     : input, two's complement when is_signed = 1, unsigned otherwise
//   is_signed : selects signed or unsigned output range
//   clamped   : value limited to the OUT_WIDTH range
//   sat       : 1 when value was outside the range and got clamped
module sat_clamp #(
  parameter int unsigned WORK_W    = 41,
  parameter int unsigned OUT_WIDTH = 24
) (
  input  logic [WORK_W-1:0]    value,
  input  logic                 is_signed,
  output logic [OUT_WIDTH-1:0] clamped,
  output logic                 sat
);

  logic [WORK_W-OUT_WIDTH:0]   s_upper;  // bits that must all match the sign bit
  logic [WORK_W-OUT_WIDTH-1:0] u_upper;  // bits that must all be zero

  assign s_upper = value[WORK_W-1:OUT_WIDTH-1];
  assign u_upper = value[WORK_W-1:OUT_WIDTH];

  always_comb begin
    clamped = value[OUT_WIDTH-1:0];
    sat     = 1'b0;
    if (is_signed) begin
      if (!(&s_upper) && (|s_upper)) begin
        sat     = 1'b1;
        clamped = value[WORK_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end else if (|u_upper) begin
      sat     = 1'b1;
      clamped = '1;
    end
  end

endmodule

// File: rtl/sample_width_conv.sv
// Audio sample width converter: extend (signed/unsigned), shift (gain) and
// saturate IN_WIDTH-bit samples to OUT_WIDTH bits through a 2-stage elastic
// valid/ready pipeline.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : input handshake
//   in_data, in_signed,
//   shift_dir, shift_amt  : sample and per-sample mode, captured together
//   out_valid/out_ready   : output handshake
//   out_data, out_sat     : converted sample and clamp flag
// Optional macro SAMPLE_WIDTH_CONV_SAT_CNT_EN adds sat_clr (in) and
// sat_count (out), a sticky count of saturated output transfers.
module sample_width_conv
  import audio_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 24,
  parameter int unsigned SHIFT_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_signed,
  input  logic                 shift_dir,
  input  logic [SHIFT_W-1:0]   shift_amt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat
`ifdef SAMPLE_WIDTH_CONV_SAT_CNT_EN
  ,
  input  logic                 sat_clr,
  output logic [SAT_CNT_W-1:0] sat_count
`endif
);

  localparam int unsigned WORK_W = work_w(IN_WIDTH, OUT_WIDTH, SHIFT_W);
  localparam int unsigned EXT_W  = WORK_W - IN_WIDTH;

  // Stage 1 state
  logic               s1_valid_q;
  logic [WORK_W-1:0]  s1_data_q;
  logic               s1_signed_q;
  logic               s1_dir_q;
  logic [SHIFT_W-1:0] s1_amt_q;

  // Stage 2 state
  logic                 out_valid_q;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic                 out_sat_q;

  logic                 s2_load;
  logic                 in_xfer;
  logic [WORK_W-1:0]    in_ext;
  logic [WORK_W-1:0]    shifted;
  logic [OUT_WIDTH-1:0] clamped;
  logic                 clamp_sat;

  assign s2_load  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign in_xfer  = in_valid && in_ready;

  // Sign bit replicated only for signed samples; zero fill otherwise.
  assign in_ext = {{EXT_W{in_data[IN_WIDTH-1] & in_signed}}, in_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_signed_q <= 1'b0;
      s1_dir_q    <= 1'b0;
      s1_amt_q    <= '0;
    end else if (in_xfer) begin
      s1_valid_q  <= 1'b1;
      s1_data_q   <= in_ext;
      s1_signed_q <= in_signed;
      s1_dir_q    <= shift_dir;
      s1_amt_q    <= shift_amt;
    end else if (s2_load) begin
      s1_valid_q  <= 1'b0;
    end
  end

  // Arithmetic right shift floors signed values; unsigned ones use logical.
  always_comb begin
    shifted = '0;
    if (!s1_dir_q) begin
      shifted = s1_data_q << s1_amt_q;
    end else if (s1_signed_q) begin
      shifted = $unsigned($signed(s1_data_q) >>> s1_amt_q);
    end else begin
      shifted = s1_data_q >> s1_amt_q;
    end
  end

  sat_clamp #(
    .WORK_W    (WORK_W),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat_clamp (
    .value     (shifted),
    .is_signed (s1_signed_q),
    .clamped   (clamped),
    .sat       (clamp_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= clamped;
        out_sat_q  <= clamp_sat;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

`ifdef SAMPLE_WIDTH_CONV_SAT_CNT_EN
  logic [SAT_CNT_W-1:0] sat_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_count_q <= '0;
    end else if (sat_clr) begin
      sat_count_q <= '0;
    end else if (out_valid_q && out_ready && out_sat_q && (sat_count_q != '1)) begin
      sat_count_q <= sat_count_q + 1'b1;
    end
  end

  assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_sample_width_conv.sv
module tb_sample_width_conv;

  localparam int unsigned IW = 16;
  localparam int unsigned OW = 24;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          in_signed = 1'b0;
  logic          shift_dir = 1'b0;
  logic [SW-1:0] shift_amt = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic          out_sat;
`ifdef SAMPLE_WIDTH_CONV_SAT_CNT_EN
  logic          sat_clr = 1'b0;
  logic [15:0]   sat_count;
`endif

  sample_width_conv #(
    .IN_WIDTH  (IW),
    .OUT_WIDTH (OW),
    .SHIFT_W   (SW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .shift_dir (shift_dir),
    .shift_amt (shift_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
`ifdef SAMPLE_WIDTH_CONV_SAT_CNT_EN
    ,
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    logic          sat;
    bit            chk_lat;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  bit   rand_rdy = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: extend to a wide integer, scale by a power of two (floor for
  // right shifts), then clamp to the output range.
  function automatic logic [OW:0] model(input logic [IW-1:0] d, input bit sg, input bit dr,
                                        input logic [SW-1:0] a);
    longint v, lo, hi;
    logic [63:0] r;
    bit s;
    if (sg) v = longint'($signed(d));
    else    v = longint'({48'd0, d});
    if (!dr) v = v * (longint'(1) << a);
    else     v = v >>> a;
    lo = sg ? -(longint'(1) << (OW - 1)) : 0;
    hi = sg ? (longint'(1) << (OW - 1)) - 1 : (longint'(1) << OW) - 1;
    s = 1'b0;
    if (v < lo) begin v = lo; s = 1'b1; end
    if (v > hi) begin v = hi; s = 1'b1; end
    r = v;
    return {s, r[OW-1:0]};
  endfunction

  // Called at posedge+1; returns at the posedge+1 following acceptance.
  task automatic send(input logic [IW-1:0] d, input bit sg, input bit dr,
                      input logic [SW-1:0] a, input bit lat);
    exp_t e;
    int   n;
    {e.sat, e.data} = model(d, sg, dr, a);
    e.chk_lat = lat;
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = sg;
    shift_dir = dr;
    shift_amt = a;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
    end else begin
      e.cyc = cyc + 2;
      q.push_back(e);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    #1;
  endtask

  // Monitor: every presented output is compared against the queue head,
  // including held cycles under backpressure; popped only on transfer.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        check("out_data", out_data, q[0].data);
        check("out_sat", out_sat, q[0].sat);
        if (out_ready) begin
          if (q[0].chk_lat) check("latency", cyc, q[0].cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
`ifdef SAMPLE_WIDTH_CONV_SAT_CNT_EN
    check("rst_sat_count", sat_count, 0);
`endif
    @(posedge clk);
    #1;

    // Directed cases with out_ready held high (latency checked)
    send(16'h8000, 1, 0, 0, 1);
    drain();
    send(16'h8000, 0, 0, 0, 1);
    drain();
    send(16'h7FFF, 1, 0, 9, 1);
    send(16'h8000, 1, 0, 9, 1);
    drain();
    @(posedge clk);
    #1;
`ifdef SAMPLE_WIDTH_CONV_SAT_CNT_EN
    check("sat_count_2", sat_count, 2);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    check("sat_count_clr", sat_count, 0);
`endif
    send(16'h8001, 1, 1, 4, 1);
    send(16'hFFFF, 0, 0, 15, 1);
    send(16'h0001, 1, 1, 15, 1);
    drain();

    // Backpressure: 4 back-to-back samples, out_ready low for 5 cycles
    out_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(IW'(i), 1, 0, 0, 0);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bp_accepts", acc_cnt, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_hold_data", out_data, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_stream_valid", out_valid, 1);
        end
      end
    join
    drain();

    // Reset with two samples in flight
    out_ready = 1'b0;
    send(16'h1234, 1, 0, 1, 0);
    send(16'h5678, 0, 1, 2, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_no_out", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Randomised stream with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      send(IW'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
           SW'($urandom_range(0, (1 << SW) - 1)), 0);
    end
    rand_rdy = 0;
    #1;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_width_conv.md
Name: sample_width_conv

Overview:
- Parametrised, pipelined successor to the fixed 16-to-24 immediate extender.
- Converts a stream of IN_WIDTH-bit audio samples to OUT_WIDTH bits. Per sample it selects signed or unsigned extension, applies an optional left or right shift (gain), and saturates.
- Sits between the codec deserialiser and the sample FIFO/processor load path.
- valid/ready handshake on both sides, 2-stage elastic pipeline.

Parameters:
- IN_WIDTH, 16, input sample width (>=2).
- OUT_WIDTH, 24, output sample width (>=2; may be smaller than IN_WIDTH).
- SHIFT_W, 4, width of shift_amt; maximum shift is 2**SHIFT_W-1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts the input sample this cycle.
- in_data  in  IN_WIDTH  input sample.
- in_signed  in  1  1 = two's complement sample, 0 = unsigned; sampled with in_data.
- shift_dir  in  1  0 = left shift, 1 = right shift; sampled with in_data.
- shift_amt  in  SHIFT_W  shift distance; sampled with in_data.
- out_valid  out  1  output sample present.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_WIDTH  converted sample.
- out_sat  out  1  out_data was clamped; qualified by out_valid.

Behaviour:
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_data, in_signed, shift_dir and shift_amt are captured together at the input transfer.
- Internal working width is WORK_W = max(IN_WIDTH,OUT_WIDTH) + 2**SHIFT_W + 1.
- Stage 1 (S1) extends in_data to WORK_W bits:
  - Sign-extends when in_signed = 1, zero-extends when in_signed = 0.
  - Registers the extended value, the mode bits and s1_valid.
- Stage 2 (S2) computes the shift result:
  - Left shift by shift_amt, zero fill.
  - Right shift by shift_amt: arithmetic if signed, logical if unsigned. Truncation toward negative infinity (floor), no rounding.
- S2 then saturates and registers the result as out_data, out_sat and out_valid:
  - Signed range is [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1].
  - Unsigned range is [0, 2**OUT_WIDTH-1].
  - A value outside the range is clamped to the nearest bound and out_sat = 1; otherwise out_sat = 0.
- Latency: an input accepted in cycle N appears on the outputs in cycle N+2 when out_ready is held high. Throughput is 1 sample/cycle.
- Elastic control:
  - S2 loads when !out_valid || out_ready.
  - S1 advances into S2 when s1_valid and S2 loads.
  - in_ready = !s1_valid || (S2 loads). in_ready is combinational from state and out_ready only; it never depends on in_valid.
  - When out_ready is low, up to 2 samples are held. No sample is dropped or duplicated, and order is preserved.
- Output stability: while out_valid && !out_ready, out_data and out_sat hold stable.
- Simultaneous input transfer, S1-to-S2 move and output transfer in one cycle is legal; full throughput is kept.
- Reset values: out_valid = 0, out_data = 0, out_sat = 0, s1_valid = 0, in_ready = 1 while reset is deasserted and the pipe is empty.
- Reset asserted mid-stream discards all in-flight samples immediately (asynchronous).
- A shift_amt of 0 passes the extended value straight to saturation.

Optional Feature:
- Macro: SAMPLE_WIDTH_CONV_SAT_CNT_EN.
- Defined:
  - Adds input sat_clr (1) and output sat_count (16).
  - sat_count increments on each output transfer with out_sat = 1 and sticks at 16'hFFFF.
  - sat_clr forces sat_count to 0 and takes priority over the increment.
  - sat_count resets to 0.
- Undefined: neither port nor the counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package audio_pkg holds:
  - function clog2;
  - function for WORK_W;
  - localparam SAT_CNT_W = 16.
- One natural sub-module, sat_clamp: combinational clamp of a WORK_W value to OUT_WIDTH with signed/unsigned select. It outputs the clamped value and the sat flag and is reused by the mixer.

Test Plan (all with defaults, IN_WIDTH=16, OUT_WIDTH=24, SHIFT_W=4):
- in_data=16'h8000, signed, shift 0, out_ready=1 -> out_data=24'hFF8000, out_sat=0, exactly 2 cycles after accept.
- in_data=16'h8000, unsigned, shift 0 -> out_data=24'h008000, out_sat=0.
- Saturation, signed, left shift 9:
  - in_data=16'h7FFF -> out_data=24'h7FFFFF, out_sat=1.
  - in_data=16'h8000 -> out_data=24'h800000, out_sat=1.
  - sat_count=2 when the macro is defined.
- Right shift, signed: in_data=16'h8001, right shift 4 -> 24'hFFF800 (-2048, floor).
- Backpressure: 4 back-to-back samples 1,2,3,4 with out_ready=0 for 5 cycles:
  - in_ready drops after 2 accepts and out_data holds 1 stable.
  - After release the outputs are 1,2,3,4 in order, one per cycle.
- Reset mid-stream: assert reset with 2 samples in flight -> out_valid=0 immediately, and in_ready=1 with no stale output after release.
